// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Fetch/debug arbiter and single-outstanding read sequencer for the
//            single-port instruction memory, with debug starvation protection.
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int BUS          = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           f_req,
    input  logic [BUS-1:0] f_addr,
    output logic           f_gnt,
    output logic           f_rvalid,
    output logic [BUS-1:0] f_rdata,
    input  logic           d_req,
    input  logic [BUS-1:0] d_addr,
    output logic           d_gnt,
    output logic           d_rvalid,
    output logic [BUS-1:0] d_rdata,
    output logic [BUS-1:0] mem_addr,
    input  logic [BUS-1:0] mem_data,
    output logic           busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] c_LAT_INIT   = 3'(MEM_LATENCY);
    localparam logic [3:0] c_STARVE_MAX = 4'(STARVE_LIMIT);

    state_t         r_state;
    state_t         w_state_nxt;
    logic           r_owner;        // 1: debug owns the outstanding access
    logic [2:0]     r_lat_cnt;
    logic [3:0]     r_starve_cnt;
    logic [BUS-1:0] r_mem_addr;
    logic [BUS-1:0] r_f_rdata;
    logic [BUS-1:0] r_d_rdata;
    logic           r_f_rvalid;
    logic           r_d_rvalid;

    logic           w_d_win;
    logic           w_f_gnt;
    logic           w_d_gnt;
    logic           w_done;

    // Grants are suppressed while reset is held so nothing is accepted then.
    always_comb begin
        w_state_nxt = r_state;
        w_d_win     = d_req && (!f_req || (r_starve_cnt == c_STARVE_MAX));
        w_f_gnt     = 1'b0;
        w_d_gnt     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_d_gnt = !reset && w_d_win;
                w_f_gnt = !reset && f_req && !w_d_win;
                if (w_f_gnt || w_d_gnt) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_done = (r_lat_cnt == 3'd1);
                if (w_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= 1'b0;
            r_lat_cnt    <= 3'd0;
            r_starve_cnt <= 4'd0;
            r_mem_addr   <= '0;
            r_f_rdata    <= '0;
            r_d_rdata    <= '0;
            r_f_rvalid   <= 1'b0;
            r_d_rvalid   <= 1'b0;
        end else begin
            r_f_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            if (w_f_gnt || w_d_gnt) begin
                r_mem_addr <= w_d_gnt ? d_addr : f_addr;
                r_owner    <= w_d_gnt;
                r_lat_cnt  <= c_LAT_INIT;
            end else if (r_state == ST_WAIT) begin
                r_lat_cnt <= r_lat_cnt - 3'd1;
                if (w_done) begin
                    if (r_owner) begin
                        r_d_rdata  <= mem_data;
                        r_d_rvalid <= 1'b1;
                    end else begin
                        r_f_rdata  <= mem_data;
                        r_f_rvalid <= 1'b1;
                    end
                end
            end
            // Saturating count of fetch wins that left debug waiting.
            if (w_d_gnt) begin
                r_starve_cnt <= 4'd0;
            end else if (w_f_gnt && d_req && (r_starve_cnt < c_STARVE_MAX)) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end
    end

    assign f_gnt    = w_f_gnt;
    assign d_gnt    = w_d_gnt;
    assign f_rvalid = r_f_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign f_rdata  = r_f_rdata;
    assign d_rdata  = r_d_rdata;
    assign mem_addr = r_mem_addr;
    assign busy     = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Directed self-checking bench for imem_arbiter at latencies 1 and 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] mem [16];

    // Instance A: MEM_LATENCY = 1
    logic        a_f_req = 1'b0, a_d_req = 1'b0;
    logic [31:0] a_f_addr = '0, a_d_addr = '0;
    logic        a_f_gnt, a_d_gnt, a_f_rvalid, a_d_rvalid, a_busy;
    logic [31:0] a_f_rdata, a_d_rdata, a_mem_addr;
    logic [31:0] a_mem_data = '0;

    // Instance B: MEM_LATENCY = 3
    logic        b_f_req = 1'b0, b_d_req = 1'b0;
    logic [31:0] b_f_addr = '0, b_d_addr = '0;
    logic        b_f_gnt, b_d_gnt, b_f_rvalid, b_d_rvalid, b_busy;
    logic [31:0] b_f_rdata, b_d_rdata, b_mem_addr;
    logic [31:0] b_mem_data = '0;

    imem_arbiter #(.BUS(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .reset(reset),
        .f_req(a_f_req), .f_addr(a_f_addr), .f_gnt(a_f_gnt),
        .f_rvalid(a_f_rvalid), .f_rdata(a_f_rdata),
        .d_req(a_d_req), .d_addr(a_d_addr), .d_gnt(a_d_gnt),
        .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .mem_addr(a_mem_addr), .mem_data(a_mem_data), .busy(a_busy)
    );

    imem_arbiter #(.BUS(32), .MEM_LATENCY(3), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .reset(reset),
        .f_req(b_f_req), .f_addr(b_f_addr), .f_gnt(b_f_gnt),
        .f_rvalid(b_f_rvalid), .f_rdata(b_f_rdata),
        .d_req(b_d_req), .d_addr(b_d_addr), .d_gnt(b_d_gnt),
        .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_data(b_mem_data), .busy(b_busy)
    );

    // Memory drives its read port on the falling edge from the word address.
    always @(negedge clk) begin
        a_mem_data <= mem[a_mem_addr[5:2]];
        b_mem_data <= mem[b_mem_addr[5:2]];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic        f_req;
        logic [31:0] f_addr;
        logic        d_req;
        logic [31:0] d_addr;
        logic        f_gnt;
        logic        d_gnt;
        logic        f_rv;
        logic        d_rv;
        logic [31:0] f_rd;
        logic [31:0] d_rd;
        logic [31:0] maddr;
        logic        busy;
    } vec_t;

    vec_t vecs [12];

    logic exp_d   [10];
    logic [3:0] exp_cnt [10];

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
        mem[4] = 32'hE3A0_0001;
        mem[2] = 32'h1234_5678;

        //             freq  faddr       dreq  daddr       fg    dg    frv   drv   frd           drd           maddr     busy
        vecs[0]  = '{1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h00, 1'b0};
        vecs[1]  = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'h10, 1'b1};
        vecs[2]  = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hE3A00001, 32'h0,        32'h10, 1'b0};
        vecs[3]  = '{1'b0, 32'h0,  1'b1, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0, 32'hE3A00001, 32'h0,        32'h10, 1'b0};
        vecs[4]  = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hE3A00001, 32'h0,        32'h08, 1'b1};
        vecs[5]  = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hE3A00001, 32'h12345678, 32'h08, 1'b0};
        vecs[6]  = '{1'b1, 32'h17, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 1'b0, 32'hE3A00001, 32'h12345678, 32'h08, 1'b0};
        vecs[7]  = '{1'b0, 32'h0,  1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, 32'hE3A00001, 32'h12345678, 32'h17, 1'b1};
        vecs[8]  = '{1'b0, 32'h0,  1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA0000005, 32'h12345678, 32'h17, 1'b0};
        vecs[9]  = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0000005, 32'h12345678, 32'h04, 1'b1};
        vecs[10] = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA0000005, 32'hA0000001, 32'h04, 1'b0};
        vecs[11] = '{1'b0, 32'h0,  1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hA0000005, 32'hA0000001, 32'h04, 1'b0};

        exp_d   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_cnt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};

        // Reset asserted with a request pending: nothing may be granted.
        a_f_req  = 1'b1;
        a_f_addr = 32'h10;
        @(posedge clk); #4;
        chk("rst_f_gnt",    32'(a_f_gnt), 32'd0);
        chk("rst_busy",     32'(a_busy), 32'd0);
        chk("rst_f_rvalid", 32'(a_f_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(a_d_rvalid), 32'd0);
        chk("rst_f_rdata",  a_f_rdata, 32'd0);
        chk("rst_d_rdata",  a_d_rdata, 32'd0);
        chk("rst_mem_addr", a_mem_addr, 32'd0);
        a_f_req = 1'b0;
        #2 reset = 1'b0;
        @(posedge clk); #4;
        chk("post_rst_busy",  32'(a_busy), 32'd0);
        chk("post_rst_cnt",   32'(dut_a.r_starve_cnt), 32'd0);
        chk("post_rst_gnt",   32'(a_f_gnt | a_d_gnt), 32'd0);

        // Table-driven cycle vectors on the latency-1 instance.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            a_f_req  = vecs[i].f_req;
            a_f_addr = vecs[i].f_addr;
            a_d_req  = vecs[i].d_req;
            a_d_addr = vecs[i].d_addr;
            #3;
            chk("vec_f_gnt",    32'(a_f_gnt),    32'(vecs[i].f_gnt));
            chk("vec_d_gnt",    32'(a_d_gnt),    32'(vecs[i].d_gnt));
            chk("vec_f_rvalid", 32'(a_f_rvalid), 32'(vecs[i].f_rv));
            chk("vec_d_rvalid", 32'(a_d_rvalid), 32'(vecs[i].d_rv));
            chk("vec_f_rdata",  a_f_rdata,       vecs[i].f_rd);
            chk("vec_d_rdata",  a_d_rdata,       vecs[i].d_rd);
            chk("vec_mem_addr", a_mem_addr,      vecs[i].maddr);
            chk("vec_busy",     32'(a_busy),     32'(vecs[i].busy));
        end

        // Starvation: both requesters held; expect F,F,F,F,D repeating.
        begin
            int ng = 0;
            @(posedge clk); #1;
            a_f_req = 1'b1; a_f_addr = 32'h20;
            a_d_req = 1'b1; a_d_addr = 32'h24;
            for (int c = 0; c < 40 && ng < 10; c++) begin
                #3;
                chk("one_gnt", 32'(a_f_gnt & a_d_gnt), 32'd0);
                if (a_f_gnt || a_d_gnt) begin
                    chk("starve_order", 32'(a_d_gnt), 32'(exp_d[ng]));
                    chk("starve_cnt",   32'(dut_a.r_starve_cnt), 32'(exp_cnt[ng]));
                    ng++;
                end
                @(posedge clk); #1;
            end
            chk("starve_grants", 32'(ng), 32'd10);
            a_f_req = 1'b0; a_d_req = 1'b0;
            repeat (3) @(posedge clk);
        end

        // Back-to-back fetches on the latency-3 instance.
        @(posedge clk); #1;
        b_f_req = 1'b1; b_f_addr = 32'h0C;
        for (int c = 0; c <= 12; c++) begin
            #3;
            chk("b2b_f_gnt",    32'(b_f_gnt),    32'((c % 4) == 0));
            chk("b2b_f_rvalid", 32'(b_f_rvalid), 32'(((c % 4) == 0) && (c != 0)));
            chk("b2b_busy",     32'(b_busy),     32'((c % 4) != 0));
            if (c == 4) chk("b2b_f_rdata", b_f_rdata, 32'hA0000003);
            @(posedge clk); #1;
        end
        b_f_req = 1'b0;
        repeat (5) @(posedge clk);

        // Reset in the middle of a latency-3 access.
        #1;
        b_f_req = 1'b1; b_f_addr = 32'h10;
        #3 chk("rw_gnt_c0", 32'(b_f_gnt), 32'd1);
        @(posedge clk); #1;
        b_f_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #3;
        chk("rw_busy_rst",   32'(b_busy), 32'd0);
        chk("rw_rdata_rst",  b_f_rdata, 32'd0);
        chk("rw_maddr_rst",  b_mem_addr, 32'd0);
        #2 reset = 1'b0;
        @(posedge clk); #4;
        chk("rw_rvalid_c3", 32'(b_f_rvalid), 32'd0);
        @(posedge clk); #4;
        chk("rw_rvalid_c4", 32'(b_f_rvalid), 32'd0);
        chk("rw_busy_c4",   32'(b_busy), 32'd0);
        @(posedge clk); #1;
        b_f_req = 1'b1; b_f_addr = 32'h08;
        #3 chk("rw_regrant", 32'(b_f_gnt), 32'd1);
        @(posedge clk); #1;
        b_f_req = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("rw_rvalid_after", 32'(b_f_rvalid), 32'd1);
        chk("rw_rdata_after",  b_f_rdata, 32'h12345678);
        chk("rw_d_rvalid",     32'(b_d_rvalid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
